spi_slave_responder: RTL and testbench
======================================

// Module: spi_slave_responder
// PURPOSE
//  SPI mode-0 slave. It is the far-end counterpart of the transceiver_integration SPI master.
//  It oversamples SCLK/SS/MOSI on CLK_48MHZ, deserialises MOSI bytes (MSB first) and serialises
//  response bytes onto MISO. It stands in for the radio transceiver in system sims, and is
//  reused as the slave port for board-to-board links.
// PARAMETERS
//  SYNC_STAGES    2      synchroniser flops on SCLK, SS and MOSI (>=2)
//  UNDERRUN_BYTE  8'hFF  byte shifted out when the TX buffer is empty at a byte boundary
// PORTS
//  CLK_48MHZ      in   1  system clock, 48 MHz
//  BUF2_PBRST_T9  in   1  asynchronous active-low reset
//  SCLK           in   1  SPI clock from master; idles low (CPOL=0)
//  SS             in   1  slave select; active low
//  MOSI           in   1  master-out data
//  MISO           out  1  slave-out data; tx_shift[7] while selected, else 1
//  MISO_OE        out  1  1 while FRAME_ACTIVE (top level tri-states MISO with it)
//  TX_DATA        in   8  next response byte
//  TX_LOAD        in   1  write TX_DATA into the TX buffer; accepted only when TX_READY=1
//  TX_READY       out  1  TX buffer empty
//  RX_DATA        out  8  last complete received byte; holds until the next byte completes
//  RX_VALID       out  1  1-cycle pulse when RX_DATA updates
//  FRAME_ACTIVE   out  1  1 while in LOAD or SHIFT
//  FRAME_DONE     out  1  1-cycle pulse on detected SS rise
//  BYTE_COUNT     out  8  complete bytes received this frame; wraps 255->0
//  UNDERRUN       out  1  sticky; set when UNDERRUN_BYTE is sent; cleared at frame start
// BEHAVIOUR
//  Reset values:
//   - MISO=1, MISO_OE=0, TX_READY=1, RX_DATA=0, RX_VALID=0, FRAME_ACTIVE=0, FRAME_DONE=0,
//     BYTE_COUNT=0, UNDERRUN=0.
//   - Shift regs, bit_cnt and TX buffer are cleared. State=IDLE.
//  Sync/edges:
//   - Each input passes SYNC_STAGES flops, then one history flop for edge detect.
//   - A pin edge is acted on SYNC_STAGES+1 cycles later.
//   - Requirement on the master: SCLK high and low times >=6 CLK cycles; SS setup/hold to SCLK >=6 CLK.
//  FSM:
//   - IDLE: SS fall -> LOAD.
//   - LOAD (1 cycle):
//      - tx_shift <= buffer if full, else UNDERRUN_BYTE (and set UNDERRUN).
//      - Buffer marked empty.
//      - bit_cnt=0, BYTE_COUNT=0; UNDERRUN cleared first, then set if the buffer was empty.
//      - -> SHIFT.
//   - SHIFT:
//      - SCLK rise: rx_shift <= {rx_shift[6:0],MOSI_sync}; bit_cnt++.
//      - bit_cnt reaching 8: RX_DATA <= assembled byte, RX_VALID pulses the next cycle,
//        BYTE_COUNT++, bit_cnt=0, reload_pending=1.
//      - SCLK fall, reload_pending=0: tx_shift <= {tx_shift[6:0],1'b0}.
//      - SCLK fall, reload_pending=1: reload tx_shift as in LOAD; clear reload_pending.
//      - SS rise: -> IDLE, FRAME_DONE pulse. A partial byte is discarded (no RX_VALID),
//        bit_cnt and reload_pending are cleared, TX buffer contents are kept.
//  Simultaneous events:
//   - SS rise detected in the same cycle as an SCLK edge: SS rise wins and the edge is ignored.
//   - SS fall while in LOAD/SHIFT cannot occur; SS fall in IDLE is the only entry.
//  TX buffer:
//   - TX_LOAD with TX_READY=1 fills it; TX_READY falls the next cycle.
//   - TX_LOAD with TX_READY=0 is ignored and the buffer is unchanged.
//   - TX_LOAD in the same cycle as a reload consumes the old buffer contents. The new byte
//     is accepted only if TX_READY was 1 in that cycle. In that case it is forwarded
//     straight to tx_shift and the buffer stays empty.
//  MISO timing:
//   - The first bit is valid within SYNC_STAGES+2 cycles of the SS pin fall.
//   - Later bits are valid within SYNC_STAGES+2 cycles of an SCLK pin fall.
//  Reset mid-frame: everything returns to reset values immediately (async). MISO_OE drops
//   asynchronously.
// TESTING
//  1. Reset values: hold reset 10 clocks -> all outputs at reset values; SS low while in
//     reset -> no frame starts.
//  2. Single byte: TX_LOAD 8'h3C, then frame with MOSI=8'hA5 at SCLK 2 MHz ->
//     MISO bits 0,0,1,1,1,1,0,0; RX_DATA=8'hA5; one RX_VALID; BYTE_COUNT=1;
//     FRAME_DONE after SS rise; UNDERRUN=0.
//  3. Back-to-back bytes: load 8'h11, refill 8'h22 when TX_READY; 2-byte frame MOSI
//     8'h5A,8'hC3 -> MISO 8'h11,8'h22; RX_VALID twice with 5A then C3; BYTE_COUNT=2.
//  4. Underrun: no TX_LOAD; 1-byte frame -> MISO=8'hFF, UNDERRUN=1. Next frame with a loaded
//     byte -> UNDERRUN clears at LOAD.
//  5. Abort: SS rises after 5 SCLK rises -> no RX_VALID, FRAME_DONE=1. Next frame with
//     MOSI 8'h81 -> RX_DATA=8'h81 (bit alignment restored).
//  6. Reset mid-frame after 3 bits -> MISO_OE=0, state IDLE. Next full frame receives
//     8'h7E correctly.

Source files
------------

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: oversamples SCLK/SS/MOSI on the system clock, receives MOSI bytes MSB first
// and serialises buffered response bytes onto MISO.
module spi_slave_responder #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter logic [7:0]  UNDERRUN_BYTE = 8'hFF
) (
   input  logic       CLK_48MHZ,
   input  logic       BUF2_PBRST_T9,
   input  logic       SCLK,
   input  logic       SS,
   input  logic       MOSI,
   output logic       MISO,
   output logic       MISO_OE,
   input  logic [7:0] TX_DATA,
   input  logic       TX_LOAD,
   output logic       TX_READY,
   output logic [7:0] RX_DATA,
   output logic       RX_VALID,
   output logic       FRAME_ACTIVE,
   output logic       FRAME_DONE,
   output logic [7:0] BYTE_COUNT,
   output logic       UNDERRUN
);

   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned BIT_CNT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } state_e;

   logic                   clk;
   logic                   rst_n;

   assign clk   = CLK_48MHZ;
   assign rst_n = BUF2_PBRST_T9;

   // Input synchronisers plus one history flop for edge detection
   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] ss_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sclk_hist_q;
   logic                   ss_hist_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         ss_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_hist_q <= 1'b0;
         ss_hist_q   <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
         sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
         ss_hist_q   <= ss_sync_q[SYNC_STAGES-1];
      end
   end

   logic sclk_s;
   logic ss_s;
   logic mosi_s;
   logic sclk_rise;
   logic sclk_fall;
   logic ss_rise;
   logic ss_fall;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_hist_q;
   assign sclk_fall = ~sclk_s & sclk_hist_q;
   assign ss_rise   = ss_s & ~ss_hist_q;
   assign ss_fall   = ~ss_s & ss_hist_q;

   state_e state_q;
   state_e state_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (ss_fall) state_d = ST_LOAD;
         ST_LOAD:  state_d = ss_rise ? ST_IDLE : ST_SHIFT;
         ST_SHIFT: if (ss_rise) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   logic [BYTE_W-1:0]    tx_shift_q,   tx_shift_d;
   logic [BYTE_W-2:0]    rx_shift_q,   rx_shift_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q,    bit_cnt_d;
   logic [BYTE_W-1:0]    tx_buf_q,     tx_buf_d;
   logic                 tx_ready_q,   tx_ready_d;
   logic                 reload_pend_q, reload_pend_d;
   logic                 under_pend_q, under_pend_d;
   logic [BYTE_W-1:0]    rx_data_q,    rx_data_d;
   logic                 rx_valid_q,   rx_valid_d;
   logic [BYTE_W-1:0]    byte_count_q, byte_count_d;
   logic                 underrun_q,   underrun_d;
   logic                 frame_done_q, frame_done_d;
   logic                 frame_act_q,  frame_act_d;
   logic                 miso_q,       miso_d;

   // Byte for the next tx_shift load: buffered byte, else a same-cycle TX_LOAD, else filler
   logic [BYTE_W-1:0]    reload_byte;
   logic                 reload_under;

   assign reload_byte  = !tx_ready_q ? tx_buf_q : (TX_LOAD ? TX_DATA : UNDERRUN_BYTE);
   assign reload_under = tx_ready_q & ~TX_LOAD;

   always_comb begin
      tx_shift_d    = tx_shift_q;
      rx_shift_d    = rx_shift_q;
      bit_cnt_d     = bit_cnt_q;
      tx_buf_d      = tx_buf_q;
      tx_ready_d    = tx_ready_q;
      reload_pend_d = reload_pend_q;
      under_pend_d  = under_pend_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = 1'b0;
      byte_count_d  = byte_count_q;
      underrun_d    = underrun_q;
      frame_done_d  = 1'b0;

      if (TX_LOAD && tx_ready_q) begin
         tx_buf_d   = TX_DATA;
         tx_ready_d = 1'b0;
      end

      unique case (state_q)
         ST_LOAD: begin
            tx_shift_d    = reload_byte;
            tx_ready_d    = 1'b1;
            bit_cnt_d     = '0;
            byte_count_d  = '0;
            underrun_d    = reload_under;
            under_pend_d  = 1'b0;
            reload_pend_d = 1'b0;
            rx_shift_d    = '0;
            if (ss_rise) frame_done_d = 1'b1;
         end
         ST_SHIFT: begin
            if (ss_rise) begin
               frame_done_d  = 1'b1;
               bit_cnt_d     = '0;
               rx_shift_d    = '0;
               reload_pend_d = 1'b0;
               under_pend_d  = 1'b0;
            end else if (sclk_rise) begin
               rx_shift_d = {rx_shift_q[BYTE_W-3:0], mosi_s};
               // A filler byte counts as sent once the master samples its first bit
               if (under_pend_q) begin
                  underrun_d   = 1'b1;
                  under_pend_d = 1'b0;
               end
               if (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1)) begin
                  rx_data_d     = {rx_shift_q, mosi_s};
                  rx_valid_d    = 1'b1;
                  byte_count_d  = byte_count_q + 8'd1;
                  bit_cnt_d     = '0;
                  reload_pend_d = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end else if (sclk_fall) begin
               if (reload_pend_q) begin
                  tx_shift_d    = reload_byte;
                  tx_ready_d    = 1'b1;
                  under_pend_d  = reload_under;
                  reload_pend_d = 1'b0;
               end else begin
                  tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
               end
            end
         end
         default: ;
      endcase

      frame_act_d = (state_d != ST_IDLE);
      miso_d      = (state_d == ST_SHIFT) ? tx_shift_d[BYTE_W-1] : 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_shift_q    <= '0;
         rx_shift_q    <= '0;
         bit_cnt_q     <= '0;
         tx_buf_q      <= '0;
         tx_ready_q    <= 1'b1;
         reload_pend_q <= 1'b0;
         under_pend_q  <= 1'b0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         byte_count_q  <= '0;
         underrun_q    <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_act_q   <= 1'b0;
         miso_q        <= 1'b1;
      end else begin
         tx_shift_q    <= tx_shift_d;
         rx_shift_q    <= rx_shift_d;
         bit_cnt_q     <= bit_cnt_d;
         tx_buf_q      <= tx_buf_d;
         tx_ready_q    <= tx_ready_d;
         reload_pend_q <= reload_pend_d;
         under_pend_q  <= under_pend_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         byte_count_q  <= byte_count_d;
         underrun_q    <= underrun_d;
         frame_done_q  <= frame_done_d;
         frame_act_q   <= frame_act_d;
         miso_q        <= miso_d;
      end
   end

   assign MISO         = miso_q;
   assign MISO_OE      = frame_act_q;
   assign FRAME_ACTIVE = frame_act_q;
   assign TX_READY     = tx_ready_q;
   assign RX_DATA      = rx_data_q;
   assign RX_VALID     = rx_valid_q;
   assign BYTE_COUNT   = byte_count_q;
   assign UNDERRUN     = underrun_q;
   assign FRAME_DONE   = frame_done_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Randomised SPI-master bench for spi_slave_responder with a queue-based scoreboard.
module tb_spi_slave_responder;

   logic       CLK_48MHZ = 1'b0;
   logic       BUF2_PBRST_T9;
   logic       SCLK, SS, MOSI, TX_LOAD;
   logic [7:0] TX_DATA;
   logic       MISO, MISO_OE, TX_READY, RX_VALID, FRAME_ACTIVE, FRAME_DONE, UNDERRUN;
   logic [7:0] RX_DATA, BYTE_COUNT;

   spi_slave_responder dut (
      .CLK_48MHZ(CLK_48MHZ), .BUF2_PBRST_T9(BUF2_PBRST_T9), .SCLK(SCLK), .SS(SS), .MOSI(MOSI),
      .MISO(MISO), .MISO_OE(MISO_OE), .TX_DATA(TX_DATA), .TX_LOAD(TX_LOAD), .TX_READY(TX_READY),
      .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .FRAME_ACTIVE(FRAME_ACTIVE),
      .FRAME_DONE(FRAME_DONE), .BYTE_COUNT(BYTE_COUNT), .UNDERRUN(UNDERRUN)
   );

   always #10 CLK_48MHZ = ~CLK_48MHZ;

   localparam logic [7:0] FILLER = 8'hFF;
   localparam int HALF = 12;

   typedef struct { logic [7:0] data; logic [7:0] cnt; } rx_exp_t;
   typedef struct { logic under; logic [7:0] cnt; } done_exp_t;

   rx_exp_t    exp_rx[$];
   done_exp_t  exp_done[$];
   logic [7:0] exp_miso[$];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   // Output monitor: pops expectations whenever the DUT presents a result
   rx_exp_t    mon_rx;
   done_exp_t  mon_done;
   logic [7:0] mon_byte = 8'h00;
   int         mon_bits = 0;
   logic       sclk_prev = 1'b0;

   always @(negedge CLK_48MHZ) begin
      if (RX_VALID) begin
         if (exp_rx.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL rx_unexpected: got RX_DATA %02h with no byte expected", RX_DATA);
         end else begin
            mon_rx = exp_rx.pop_front();
            chk("rx_data", RX_DATA, mon_rx.data);
            chk("rx_byte_count", BYTE_COUNT, mon_rx.cnt);
         end
      end
      if (FRAME_DONE) begin
         if (exp_done.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL done_unexpected: got FRAME_DONE with no frame expected");
         end else begin
            mon_done = exp_done.pop_front();
            chk("underrun", 8'(UNDERRUN), 8'(mon_done.under));
            chk("frame_byte_count", BYTE_COUNT, mon_done.cnt);
         end
      end
      if (!BUF2_PBRST_T9 || SS) begin
         mon_bits = 0;
      end else if (SCLK && !sclk_prev) begin
         mon_byte = {mon_byte[6:0], MISO};
         mon_bits++;
         if (mon_bits == 8) begin
            mon_bits = 0;
            if (exp_miso.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL miso_unexpected: got byte %02h with none expected", mon_byte);
            end else begin
               chk("miso_byte", mon_byte, exp_miso.pop_front());
            end
         end
      end
      sclk_prev = SCLK;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge CLK_48MHZ);
      #1;
   endtask

   task automatic tx_load(input logic [7:0] d);
      chk("tx_ready_before_load", 8'(TX_READY), 8'd1);
      TX_DATA = d;
      TX_LOAD = 1'b1;
      wait_clk(1);
      TX_LOAD = 1'b0;
   endtask

   // One master frame: nb full bytes, or an abort after abort_rises SCLK rises
   task automatic do_frame(input int nb, input int abort_rises, input logic [7:0] mo[4],
                           input logic [7:0] tx[4], input bit ld[4], input bit bad_load);
      int  nfull;
      int  total;
      int  k;
      int  b;
      logic under;
      nfull = (abort_rises > 0) ? 0 : nb;
      under = 1'b0;
      if (ld[0]) begin
         tx_load(tx[0]);
         if (bad_load) begin
            wait_clk(2);
            chk("tx_ready_full", 8'(TX_READY), 8'd0);
            TX_DATA = ~tx[0];
            TX_LOAD = 1'b1;
            wait_clk(1);
            TX_LOAD = 1'b0;
         end
      end
      for (int i = 0; i < nfull; i++) begin
         exp_miso.push_back(ld[i] ? tx[i] : FILLER);
         if (!ld[i]) under = 1'b1;
      end
      if (abort_rises > 0) under = !ld[0];
      total = (abort_rises > 0) ? abort_rises : nb * 8;
      SS = 1'b0;
      for (int i = 0; i < total; i++) begin
         k = i / 8;
         b = i % 8;
         MOSI = mo[k][7-b];
         if (b == 0 && abort_rises == 0) exp_rx.push_back('{mo[k], 8'(k + 1)});
         wait_clk(HALF);
         SCLK = 1'b1;
         if (b == 1 && abort_rises == 0 && k + 1 < nb && ld[k+1]) begin
            tx_load(tx[k+1]);
            wait_clk(HALF - 1);
         end else begin
            wait_clk(HALF);
         end
         SCLK = 1'b0;
      end
      wait_clk(HALF);
      exp_done.push_back('{under, 8'(nfull)});
      SS = 1'b1;
      MOSI = 1'b0;
      wait_clk(20);
   endtask

   logic [7:0] mo[4];
   logic [7:0] tx[4];
   bit         ld[4];
   int         nb, ab;
   bit         bad;

   initial begin
      BUF2_PBRST_T9 = 1'b0;
      SS = 1'b0; SCLK = 1'b0; MOSI = 1'b0; TX_LOAD = 1'b0; TX_DATA = 8'h00;
      wait_clk(10);
      chk("rst_miso", 8'(MISO), 8'd1);
      chk("rst_miso_oe", 8'(MISO_OE), 8'd0);
      chk("rst_tx_ready", 8'(TX_READY), 8'd1);
      chk("rst_rx_data", RX_DATA, 8'h00);
      chk("rst_rx_valid", 8'(RX_VALID), 8'd0);
      chk("rst_frame_active", 8'(FRAME_ACTIVE), 8'd0);
      chk("rst_frame_done", 8'(FRAME_DONE), 8'd0);
      chk("rst_byte_count", BYTE_COUNT, 8'h00);
      chk("rst_underrun", 8'(UNDERRUN), 8'd0);
      SS = 1'b1;
      wait_clk(5);
      BUF2_PBRST_T9 = 1'b1;
      wait_clk(10);
      chk("idle_frame_active", 8'(FRAME_ACTIVE), 8'd0);

      // Single byte
      mo = '{8'hA5, 8'h00, 8'h00, 8'h00}; tx = '{8'h3C, 8'h00, 8'h00, 8'h00};
      ld = '{1, 0, 0, 0};
      do_frame(1, 0, mo, tx, ld, 1'b0);
      // Back-to-back bytes
      mo = '{8'h5A, 8'hC3, 8'h00, 8'h00}; tx = '{8'h11, 8'h22, 8'h00, 8'h00};
      ld = '{1, 1, 0, 0};
      do_frame(2, 0, mo, tx, ld, 1'b0);
      // Underrun, then a loaded frame clears it
      ld = '{0, 0, 0, 0};
      do_frame(1, 0, mo, tx, ld, 1'b0);
      ld = '{1, 0, 0, 0};
      do_frame(1, 0, mo, tx, ld, 1'b1);
      // Abort after 5 rises, then bit alignment restored
      mo = '{8'hFF, 8'h00, 8'h00, 8'h00};
      do_frame(1, 5, mo, tx, ld, 1'b0);
      mo = '{8'h81, 8'h00, 8'h00, 8'h00};
      do_frame(1, 0, mo, tx, ld, 1'b0);

      // Reset mid-frame after 3 bits
      tx_load(8'h99);
      SS = 1'b0;
      for (int i = 0; i < 3; i++) begin
         MOSI = 1'(i);
         wait_clk(HALF); SCLK = 1'b1;
         wait_clk(HALF); SCLK = 1'b0;
      end
      wait_clk(3);
      BUF2_PBRST_T9 = 1'b0;
      #1;
      chk("midrst_miso_oe", 8'(MISO_OE), 8'd0);
      chk("midrst_frame_active", 8'(FRAME_ACTIVE), 8'd0);
      chk("midrst_miso", 8'(MISO), 8'd1);
      chk("midrst_byte_count", BYTE_COUNT, 8'h00);
      SS = 1'b1; MOSI = 1'b0;
      wait_clk(4);
      BUF2_PBRST_T9 = 1'b1;
      wait_clk(10);
      mo = '{8'h7E, 8'h00, 8'h00, 8'h00}; tx = '{8'hC6, 8'h00, 8'h00, 8'h00};
      do_frame(1, 0, mo, tx, ld, 1'b0);

      // Randomised frames
      for (int f = 0; f < 30; f++) begin
         nb = int'($urandom_range(1, 4));
         ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 0;
         for (int i = 0; i < 4; i++) begin
            mo[i] = 8'($urandom);
            tx[i] = 8'($urandom);
            ld[i] = ($urandom_range(0, 3) != 0);
         end
         bad = ($urandom_range(0, 3) == 0);
         do_frame(nb, ab, mo, tx, ld, bad);
      end

      wait_clk(50);
      chk("rx_left", 8'(exp_rx.size()), 8'd0);
      chk("done_left", 8'(exp_done.size()), 8'd0);
      chk("miso_left", 8'(exp_miso.size()), 8'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
